// File: rtl/ysyx_24110006_issue_ctrl.sv
// ysyx_24110006_issue_ctrl
// In-order issue controller sitting between decode and EXU.
//  - Per-register scoreboard of pending writes (x0 untracked) plus an
//    in-flight counter; generates o_stall / o_issue.
//  - CSR/mret/fence ("serial") instructions issue alone into an empty
//    pipeline and block all younger issue until they retire.
//  - A decode exception drains the pipeline, then raises a one-cycle trap.
//  - An EXU redirect flushes the front end and abandons any pending trap.
// Optional feature macro: ISSUE_PERF_EN adds three 32-bit stall-cause
// counters (o_perf_raw, o_perf_full, o_perf_serial).
// A writeback with nothing in flight is illegal; all counters saturate at
// zero instead of wrapping.

module ysyx_24110006_issue_ctrl #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic             i_id_rs1_en,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs2_en,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_wen,
  input  logic             i_id_serial,
  input  logic             i_id_exc,
  input  logic             i_ex_ready,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_wb_wen,
  input  logic             i_redirect,
  output logic             o_issue,
  output logic             o_stall,
  output logic             o_flush,
  output logic             o_trap,
  output logic [CNT_W-1:0] o_inflight
`ifdef ISSUE_PERF_EN
  ,
  output logic [31:0]      o_perf_raw,
  output logic [31:0]      o_perf_full,
  output logic [31:0]      o_perf_serial
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SERIAL = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_rst_dly;
  logic [CNT_W-1:0] r_inflight;
  logic [31:0]      w_busy;
  logic             w_quiet;
  logic             w_raw;
  logic             w_full;
  logic             w_serial_block;
  logic             w_stall;
  logic             w_issue;
  logic             w_trap;

  // Remember that reset was asserted last cycle: outputs stay quiet then too.
  always_ff @(posedge i_clock) begin
    r_rst_dly <= i_reset;
  end

  assign w_quiet = i_reset || r_rst_dly;

  // x0 is hardwired zero and never has a pending write.
  assign w_busy[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_sb
      logic [CNT_W-1:0] r_cnt;
      logic             w_inc;
      logic             w_dec;

      assign w_inc = w_issue && i_id_wen && (i_id_rd == 5'(gi));
      assign w_dec = i_wb_valid && i_wb_wen && (i_wb_rd == 5'(gi));

      // Pending-write counter for register gi; simultaneous inc/dec cancel.
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          r_cnt <= '0;
        end else if (w_inc && !w_dec) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_dec && !w_inc && (r_cnt != '0)) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end

      assign w_busy[gi] = (r_cnt != '0);
    end
  endgenerate

  // Hazards use only registered state, so a writeback frees readers next cycle.
  assign w_raw = (i_id_rs1_en && (i_id_rs1 != 5'd0) && w_busy[i_id_rs1]) ||
                 (i_id_rs2_en && (i_id_rs2 != 5'd0) && w_busy[i_id_rs2]);
  assign w_full         = (r_inflight == CNT_W'(MAX_INFLIGHT));
  assign w_serial_block = i_id_serial && (r_inflight != '0);

  assign w_stall = !w_quiet && i_id_valid &&
                   (w_raw || w_full || w_serial_block || i_id_exc || (r_state != ST_RUN));
  assign w_issue = !w_quiet && i_id_valid && !w_stall && i_ex_ready &&
                   !i_redirect && !i_id_exc;

  // In-flight count: +1 per issue, -1 per retire, saturating at zero.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_inflight <= '0;
    end else if (w_issue && !i_wb_valid) begin
      r_inflight <= r_inflight + CNT_W'(1);
    end else if (i_wb_valid && !w_issue && (r_inflight != '0)) begin
      r_inflight <= r_inflight - CNT_W'(1);
    end
  end

  // Issue-mode state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and trap decode; a redirect always wins and cancels a trap.
  always_comb begin
    w_state_next = r_state;
    w_trap       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_issue && i_id_serial) begin
          w_state_next = ST_SERIAL;
        end else if (!w_quiet && i_id_valid && i_id_exc && !i_redirect) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_SERIAL: begin
        if (r_inflight == '0) begin
          w_state_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if ((r_inflight == '0) && !w_quiet) begin
          w_trap       = !i_redirect;
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
    if (i_redirect) begin
      w_state_next = ST_RUN;
    end
  end

  assign o_issue    = w_issue;
  assign o_stall    = w_stall;
  assign o_trap     = w_trap;
  assign o_flush    = !w_quiet && (i_redirect || w_trap);
  assign o_inflight = r_inflight;

`ifdef ISSUE_PERF_EN
  logic [31:0] r_perf_raw;
  logic [31:0] r_perf_full;
  logic [31:0] r_perf_serial;

  // Stall-cycle counters, one cause per cycle with priority raw > full > serial.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_perf_raw    <= '0;
      r_perf_full   <= '0;
      r_perf_serial <= '0;
    end else if (w_stall) begin
      if (w_raw) begin
        r_perf_raw <= r_perf_raw + 32'd1;
      end else if (w_full) begin
        r_perf_full <= r_perf_full + 32'd1;
      end else if (w_serial_block) begin
        r_perf_serial <= r_perf_serial + 32'd1;
      end
    end
  end

  assign o_perf_raw    = r_perf_raw;
  assign o_perf_full   = r_perf_full;
  assign o_perf_serial = r_perf_serial;
`endif

endmodule
